// File: rtl/muldiv_seq_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef logic [1:0] muldiv_state_e;

    localparam muldiv_state_e ST_IDLE = 2'd0;
    localparam muldiv_state_e ST_MUL  = 2'd1;
    localparam muldiv_state_e ST_DIV  = 2'd2;
    localparam muldiv_state_e ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] q_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] q_out
);

    // The shifted remainder keeps one extra bit so unsigned divisors at or
    // above 2^(XLEN-1) still compare correctly.
    logic [XLEN:0] shifted;

    always_comb begin
        shifted = {rem_in, q_in[XLEN-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_out = shifted[XLEN-1:0] - divisor;
            q_out   = {q_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            q_out   = {q_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// EX-stage multiply/divide sequencer: registered full-width product for MUL*,
// radix-2 restoring divider for DIV*/REM*, one-cycle done pulse per operation.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   divisor;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              neg_r;

    muldiv_op_e        op_in;
    logic              mul_sa;
    logic              mul_sb;
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic              div_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_q;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   mul_res;

    assign op_in      = muldiv_op_e'(op);
    assign mul_sa     = (op_in != OP_MULHU);
    assign mul_sb     = (op_in == OP_MUL) || (op_in == OP_MULH);
    assign ext_a      = {{XLEN{mul_sa & a[XLEN-1]}}, a};
    assign ext_b      = {{XLEN{mul_sb & b[XLEN-1]}}, b};

    // Signed divide ops (DIV, REM) have funct3[0] clear.
    assign div_signed = ~op[0];
    assign a_neg      = div_signed & a[XLEN-1];
    assign b_neg      = div_signed & b[XLEN-1];
    assign abs_a      = a_neg ? -a : a;
    assign abs_b      = b_neg ? -b : b;
    assign div_zero   = (b == '0);
    assign div_ovf    = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (rem),
        .q_in    (q),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    assign quot_fix = neg_q ? -step_q : step_q;
    assign rem_fix  = neg_r ? -step_rem : step_rem;
    assign div_res  = op_q[1] ? rem_fix : quot_fix;
    assign mul_res  = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    // Flush takes priority over everything except reset; result is only
    // written on the transition into DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_MUL;
            product <= '0;
            q       <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op_in;
                        if (!op[2]) begin
                            product <= ext_a * ext_b;
                            state   <= ST_MUL;
                        end else if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= ST_DONE;
                        end else begin
                            q       <= abs_a;
                            divisor <= abs_b;
                            rem     <= '0;
                            cnt     <= CNT_W'(XLEN-1);
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            state   <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result <= mul_res;
                    state  <= ST_DONE;
                end
                ST_DIV: begin
                    rem <= step_rem;
                    q   <= step_q;
                    if (cnt == '0) begin
                        result <= div_res;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops
// against an arithmetic reference model, and flush/reset/held-start sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    bit running = 1'b0;

    muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (running) check_output("busy_and_done", {63'd0, busy & done}, 64'd0);
    end

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        int ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        ix = x;
        iy = y;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return ix / iy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return ix % iy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o < 3'd4) return 2;
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op and wait (bounded) for done; lat counts cycles after acceptance.
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            lat++;
            if (done || lat >= 100) break;
            if (!busy) busy_ok = 1'b0;
        end
        res = result;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          busy_ok;
        apply_stimulus(o, x, y, res, lat, busy_ok);
        check_output({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check_output({name, "_result"}, {32'd0, res}, {32'd0, exp});
        check_output({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        int          cyc;
        int          pulses;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", {63'd0, busy}, 64'd0);
        check_output("reset_done", {63'd0, done}, 64'd0);
        check_output("reset_result", {32'd0, result}, 64'd0);
        reset   = 1'b1;
        running = 1'b1;

        vecs[0]  = '{"mul_7_m3",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{"mulhu_max",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{"mulhsu_m1_2",    3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2};
        vecs[3]  = '{"divu_100_7",     3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[4]  = '{"remu_100_7",     3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[5]  = '{"div_m7_2",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[6]  = '{"rem_m7_2",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[7]  = '{"rem_7_m2",       3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[8]  = '{"div_5_0",        3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{"remu_5_0",       3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{"div_ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};

        foreach (vecs[i])
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        run_and_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            run_and_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb,
                          ref_result(ro, ra, rb), ref_latency(ro, ra, rb));
        end

        // Flush during the 10th divide iteration: no done, result unchanged.
        run_and_check("pre_flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        for (cyc = 1; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_output("flush_busy", {63'd0, busy}, 64'd0);
        check_output("flush_done", {63'd0, done}, 64'd0);
        check_output("flush_result", {32'd0, result}, 64'd14);

        // Same-cycle start and flush in IDLE: the start is dropped.
        start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_output("startflush_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("flush_no_done", 64'(pulses), 64'd0);
        check_output("flush_result_kept", {32'd0, result}, 64'd14);
        run_and_check("post_flush_divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("midreset_busy", {63'd0, busy}, 64'd0);
        check_output("midreset_done", {63'd0, done}, 64'd0);
        check_output("midreset_result", {32'd0, result}, 64'd0);
        reset = 1'b1;

        // start held high through MUL and DONE: exactly one done pulse.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        pulses = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done || cyc >= 100) break;
        end
        if (done) pulses++;
        check_output("held_latency", 64'(cyc), 64'd2);
        check_output("held_result", {32'd0, result}, 64'd42);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_output("held_single_done", 64'(pulses), 64'd1);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle M-extension sequencer for the EX stage: accepts one multiply/divide operation per start handshake, drives a registered 64-bit product or a radix-2 restoring divider, and returns one XLEN result with a single-cycle done pulse. Sits beside the ALU in EX. EX holds the instruction and stalls while `start && !done`. A flush from branch resolution aborts the operation.

## Interface
Parameters:
- XLEN, 32, operand/result width
- CNT_W, $clog2(XLEN), divider iteration counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  muldiv_op_e, funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- a  in  XLEN  rs1 operand (forwarded)
- b  in  XLEN  rs2 operand (forwarded)
- flush  in  1  abort current operation
- busy  out  1  high in MUL and DIV states
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  result; held until next accepted start

## Operation
- FSM states: IDLE, MUL, DIV, DONE (muldiv_state_e).
- IDLE with start=1 and flush=0:
  - latch op, a, b;
  - MUL*: go to MUL;
  - DIV* with b==0 or signed overflow: go to DONE directly;
  - otherwise DIV* loads |a|, |b| (abs only for DIV/REM), clears the remainder, sets cnt=XLEN-1, and goes to DIV.
- MUL:
  - 2XLEN-bit product of sign/zero-extended operands: MULHSU uses a signed, b unsigned;
  - MUL and MULH use both signed; MULHU uses both unsigned;
  - product is registered; then DONE.
- MUL result selection: MUL takes the low XLEN bits; MULH, MULHSU and MULHU take the high XLEN bits.
- DIV: one restoring step per cycle.
  - rem = {rem[XLEN-2:0], q[XLEN-1]}; q <<= 1.
  - If rem >= divisor: rem -= divisor, q[0]=1.
  - cnt decrements each step; the step with cnt==0 transitions to DONE.
- Sign fix-up on entering DONE (DIV/REM only):
  - quotient negated if sign(a) != sign(b);
  - remainder negated if a is negative.
- Special cases, no iteration:
  - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (DIV/REM, a=0x8000_0000, b=0xFFFF_FFFF): DIV = a, REM = 0.
- DONE: done=1 for one cycle; result register updated on entry. Always returns to IDLE. start is ignored in DONE.
- flush: any state returns to IDLE next cycle.
  - done is not asserted that cycle or later for the aborted op; result is not updated.
  - flush and start in the same cycle: flush wins, start is dropped.
- start with flush=0 in MUL/DIV/DONE: ignored, no restart.
- Reset: state=IDLE, busy=0, done=0, result=0, cnt=0, internal registers cleared. Reset mid-operation discards the op.

## Timing
- All outputs registered or decoded from state only; no combinational path from start/a/b to done or result.
- Cycle 0 is the cycle start is accepted in IDLE.
- MUL*: MUL at cycle 1, done at cycle 2.
- DIV* normal: DIV at cycles 1..XLEN, done at cycle XLEN+1 (33 for XLEN=32).
- DIV* special case: done at cycle 1.
- busy is high exactly during MUL/DIV cycles; busy and done are never both high.
- Back-to-back: the earliest next start is accepted the cycle after done (IDLE). Minimum issue interval 3 cycles (MUL), 2 (special div).
- Flush at cycle k: IDLE at k+1; a new start is accepted at k+1.

## Structure
- riscv_pkg additions: muldiv_op_e (3-bit, funct3 values above) and muldiv_state_e (2-bit).
- Optional sub-module div_step (combinational restoring step: rem_in, q_in, divisor -> rem_out, q_out). Instantiated once; iterated by the FSM.
- Product, divisor, rem, q, cnt and neg-flags are registers inside muldiv_seq. No memories.

## Test plan
- MUL a=7, b=0xFFFF_FFFD (-3): done at cycle 2, result=0xFFFF_FFEB. MULHU 0xFFFF_FFFF*0xFFFF_FFFF: result=0xFFFF_FFFE. MULHSU a=-1, b=2: result=0xFFFF_FFFF.
- DIVU 100/7: busy cycles 1..32, done at cycle 33, result=14. REMU 100/7: result=2.
- DIV -7/2: result=0xFFFF_FFFD (-3). REM -7/2: result=0xFFFF_FFFF (-1). REM 7/-2: result=1.
- Special cases, each with done at cycle 1:
  - DIV 5/0: 0xFFFF_FFFF.
  - REMU 5/0: 5.
  - DIV 0x8000_0000/-1: 0x8000_0000.
  - REM of the same operands: 0.
- Flush at DIV iteration 10: no done pulse; result keeps its old value; IDLE next cycle. Same-cycle start+flush is dropped. A fresh DIVU 9/3 started after the flush gives done at +33 and result=3.
- reset=0 during DIV: next cycle busy=0, done=0, result=0. start held high across DONE is not restarted; only one done pulse per accepted start.
